// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports,
// destination allocation, scoreboard view and debug read.
interface reg_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
);
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NREGS-1:0]    busy_vec;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, dbg_addr,
    input  rs_data, rs_busy, busy_vec, dbg_data
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, dbg_addr,
    output rs_data, rs_busy, busy_vec, dbg_data
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with prioritised write ports, optional
// write-to-read bypass and a per-register busy scoreboard; x0 reads as zero.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input logic           clk,
  input logic           rst,
  reg_file_mp_if.slave  bus
);

  logic [XLEN-1:0]     regs_q [1:NREGS-1];
  logic [XLEN-1:0]     regs_d [1:NREGS-1];
  logic [NREGS-1:0]    busy_q;
  logic [NREGS-1:0]    busy_d;

  logic [NRD*AW-1:0]   rs_addr_s;
  logic [NWR-1:0]      wr_en_s;
  logic [NWR*AW-1:0]   wr_addr_s;
  logic [NWR*XLEN-1:0] wr_data_s;
  logic [NRD*XLEN-1:0] rs_data_s;
  logic [NRD-1:0]      rs_busy_s;

  assign rs_addr_s = bus.rs_addr;
  assign wr_en_s   = bus.wr_en;
  assign wr_addr_s = bus.wr_addr;
  assign wr_data_s = bus.wr_data;

  function automatic logic [XLEN-1:0] stored(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (a != '0) v = regs_q[a];
    else         v = '0;
    return v;
  endfunction

  // Returns {hit, data}; scanning ascending ports lets the highest index win.
  function automatic logic [XLEN:0] bypass_lookup(input logic [AW-1:0] a);
    logic [XLEN:0] r;
    r = {1'b0, stored(a)};
    for (int j = 0; j < NWR; j++) begin
      r = ((BYPASS != 0) && (a != '0) && wr_en_s[j] && (wr_addr_s[j*AW +: AW] == a))
          ? {1'b1, wr_data_s[j*XLEN +: XLEN]} : r;
    end
    return r;
  endfunction

  // Next state: writes in ascending port order, then alloc overrides the clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) begin
        regs_d[r] = (wr_en_s[j] && (wr_addr_s[j*AW +: AW] == AW'(r)))
                    ? wr_data_s[j*XLEN +: XLEN] : regs_d[r];
        busy_d[r] = (wr_en_s[j] && (wr_addr_s[j*AW +: AW] == AW'(r)))
                    ? 1'b0 : busy_d[r];
      end
      busy_d[r] = (bus.alloc_en && (bus.alloc_addr == AW'(r))) ? 1'b1 : busy_d[r];
    end
    busy_d[0] = 1'b0;
  end

  // Storage and scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports; bypass and busy are forced low while in reset.
  always_comb begin
    logic [XLEN:0]   lk;
    logic [AW-1:0]   ra;
    rs_data_s = '0;
    rs_busy_s = '0;
    lk        = '0;
    ra        = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rs_addr_s[k*AW +: AW];
      lk = bypass_lookup(ra);
      rs_data_s[k*XLEN +: XLEN] = rst ? {XLEN{1'b0}} : lk[XLEN-1:0];
      rs_busy_s[k] = ~rst & busy_q[ra] & ~lk[XLEN];
    end
  end

  assign bus.rs_data  = rs_data_s;
  assign bus.rs_busy  = rs_busy_s;
  assign bus.busy_vec = busy_q;
  assign bus.dbg_data = stored(bus.dbg_addr);

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed scoreboard bench: dut_a has two write ports with bypass, dut_b a
// single write port without bypass.
module tb_reg_file_mp;
  logic clk;
  logic rst;

  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) a_if ();
  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) b_if ();

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));
  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] obs(input int src);
    case (src)
      0:       return a_if.rs_data[31:0];
      1:       return a_if.rs_data[63:32];
      2:       return {31'd0, a_if.rs_busy[0]};
      3:       return a_if.busy_vec;
      4:       return a_if.dbg_data;
      5:       return b_if.rs_data[31:0];
      6:       return {31'd0, b_if.rs_busy[0]};
      7:       return b_if.busy_vec;
      8:       return {31'd0, a_if.rs_busy[1]};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int src, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.src);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_now();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_if.rs_addr = '0; a_if.wr_en = '0; a_if.wr_addr = '0; a_if.wr_data = '0;
    a_if.alloc_en = 1'b0; a_if.alloc_addr = '0; a_if.dbg_addr = '0;
    b_if.rs_addr = '0; b_if.wr_en = '0; b_if.wr_addr = '0; b_if.wr_data = '0;
    b_if.alloc_en = 1'b0; b_if.alloc_addr = '0; b_if.dbg_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset holds outputs low even with a write, bypass candidate and alloc.
    a_if.wr_en = 2'b01; a_if.wr_addr = {5'd0, 5'd5}; a_if.wr_data = {32'd0, 32'hDEADBEEF};
    a_if.rs_addr = {5'd0, 5'd5}; a_if.alloc_en = 1'b1; a_if.alloc_addr = 5'd5;
    a_if.dbg_addr = 5'd5;
    push("rst_rd", 0, 32'h0); push("rst_busy", 2, 32'h0); push("rst_vec", 3, 32'h0);
    sample();
    next();
    push("rst_vec2", 3, 32'h0); push("rst_dbg", 4, 32'h0);
    sample();
    next();
    rst = 1'b0;
    idle_inputs();

    // Load x5 and allocate x9, then read them back.
    a_if.wr_en = 2'b01; a_if.wr_addr = {5'd0, 5'd5}; a_if.wr_data = {32'd0, 32'hDEADBEEF};
    a_if.alloc_en = 1'b1; a_if.alloc_addr = 5'd9;
    next();
    idle_inputs();
    a_if.rs_addr = {5'd0, 5'd5}; a_if.dbg_addr = 5'd5;
    push("load_rd", 0, 32'hDEADBEEF); push("load_dbg", 4, 32'hDEADBEEF);
    push("load_vec", 3, 32'h0000_0200);
    sample();

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    push("arst_rd", 0, 32'h0); push("arst_dbg", 4, 32'h0); push("arst_vec", 3, 32'h0);
    check_now();
    next();
    rst = 1'b0;
    idle_inputs();

    // x0 protection.
    a_if.wr_en = 2'b01; a_if.wr_addr = {5'd0, 5'd0}; a_if.wr_data = {32'd0, 32'h12345678};
    a_if.alloc_en = 1'b1; a_if.alloc_addr = 5'd0; a_if.rs_addr = {5'd0, 5'd0};
    push("x0_rd", 0, 32'h0); push("x0_busy", 2, 32'h0);
    sample();
    next();
    idle_inputs();
    push("x0_vec", 3, 32'h0); push("x0_rd2", 0, 32'h0);
    sample();
    next();

    // Same-cycle bypass on port 0.
    a_if.wr_en = 2'b01; a_if.wr_addr = {5'd0, 5'd7}; a_if.wr_data = {32'd0, 32'hA5A5A5A5};
    a_if.rs_addr = {5'd0, 5'd7};
    push("byp_rd", 0, 32'hA5A5A5A5);
    sample();
    next();

    // Two ports write x3; the higher port wins, including on the bypass path.
    a_if.wr_en = 2'b11; a_if.wr_addr = {5'd3, 5'd3}; a_if.wr_data = {32'h2, 32'h1};
    a_if.rs_addr = {5'd3, 5'd7};
    push("prio_byp", 1, 32'h2); push("prio_old7", 0, 32'hA5A5A5A5);
    sample();
    next();
    idle_inputs();
    a_if.rs_addr = {5'd3, 5'd0}; a_if.dbg_addr = 5'd3;
    push("prio_rd", 1, 32'h2); push("prio_dbg", 4, 32'h2);
    sample();
    next();

    // Scoreboard: alloc x9, hold two idle cycles, then write it back.
    a_if.alloc_en = 1'b1; a_if.alloc_addr = 5'd9;
    next();
    idle_inputs();
    a_if.rs_addr = {5'd8, 5'd9};
    for (int i = 0; i < 2; i++) begin
      push("sb_busy", 2, 32'h1); push("sb_other", 8, 32'h0);
      sample();
      next();
    end
    a_if.wr_en = 2'b10; a_if.wr_addr = {5'd9, 5'd0}; a_if.wr_data = {32'h55, 32'd0};
    push("sb_wbusy", 2, 32'h0); push("sb_wvec", 3, 32'h0000_0200); push("sb_wrd", 0, 32'h55);
    sample();
    next();
    idle_inputs();
    a_if.rs_addr = {5'd0, 5'd9};
    push("sb_clr", 3, 32'h0); push("sb_rd", 0, 32'h55);
    sample();
    next();

    // Write and alloc to x4 on the same edge: set beats clear.
    a_if.wr_en = 2'b01; a_if.wr_addr = {5'd0, 5'd4}; a_if.wr_data = {32'd0, 32'hCAFE0004};
    a_if.alloc_en = 1'b1; a_if.alloc_addr = 5'd4;
    next();
    idle_inputs();
    a_if.rs_addr = {5'd0, 5'd4};
    push("col_vec", 3, 32'h0000_0010); push("col_rd", 0, 32'hCAFE0004);
    push("col_busy", 2, 32'h1);
    sample();
    next();

    // No-bypass instance: old value and busy in the write cycle, new value after.
    b_if.alloc_en = 1'b1; b_if.alloc_addr = 5'd7;
    next();
    idle_inputs();
    b_if.wr_en = 1'b1; b_if.wr_addr = 5'd7; b_if.wr_data = 32'hA5A5A5A5;
    b_if.rs_addr = {5'd0, 5'd7};
    push("nb_old", 5, 32'h0); push("nb_busy", 6, 32'h1); push("nb_vec", 7, 32'h0000_0080);
    sample();
    next();
    idle_inputs();
    b_if.rs_addr = {5'd0, 5'd7};
    push("nb_new", 5, 32'hA5A5A5A5); push("nb_busy2", 6, 32'h0); push("nb_vec2", 7, 32'h0);
    sample();
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the pipelined RISC-V core. It provides NRD combinational read ports, NWR write ports with a fixed priority order, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection. It sits between decode (reads and destination allocation) and writeback (writes and busy clear), and it replaces the single-issue two-read/one-write file.

## Interface
Parameters:
- XLEN, 32: data width.
- NREGS, 32: register count, power of two, at least 2. Register 0 is hardwired to zero.
- NRD, 2: number of read ports, at least 1.
- NWR, 1: number of write ports, at least 1.
- BYPASS, 1: when 1, reads return same-cycle write data.
- AW, $clog2(NREGS): address width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rs_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rs_data  out  NRD*XLEN  read data for each port.
- rs_busy  out  NRD  per read port, the addressed register has a pending producer.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- alloc_en  in  1  mark a destination register busy (issued instruction).
- alloc_addr  in  AW  destination register to mark.
- busy_vec  out  NREGS  full scoreboard; bit 0 is always 0.
- dbg_addr  in  AW  debug read address; never bypassed.
- dbg_data  out  XLEN  debug read data.

## Operation
- Storage: NREGS-1 registers of XLEN bits. Register 0 is not stored; all reads of address 0 return 0, and writes to it are dropped.
- Writes: each write port j with wr_en[j] and wr_addr≠0 updates its register at the clock edge. When several ports target the same address, the highest-indexed port wins.
- Reads are combinational. With BYPASS=1, if any enabled write port targets the read address (≠0), rs_data returns that port's wr_data, applying the same highest-index priority. Otherwise it returns stored data. With BYPASS=0, stored data is always returned, so a write becomes visible the cycle after.
- Scoreboard: busy[r] is one bit per register.
  - Set at the edge when alloc_en and alloc_addr=r≠0.
  - Cleared at the edge when any enabled write port targets r.
  - When set and clear coincide on the same register, set wins (a new producer has issued).
- rs_busy[k] = busy[addr_k] AND NOT (BYPASS AND a same-cycle write to addr_k). It is 0 for address 0.
- busy_vec reflects registered state only, with no bypass.
- dbg_data returns stored data, or 0 for address 0.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- Scoreboard update latency is 1 edge.
- Reset:
  - On rst assertion, all registers go to 0 and all busy bits go to 0 immediately, without waiting for clk.
  - While rst is high, writes and allocs are ignored.
  - Outputs during reset: rs_data=0, rs_busy=0, busy_vec=0 and dbg_data=0, even if wr_en is high (bypass is suppressed during reset).
- Reset released mid-stream: the first edge with rst low performs normal updates.
- Simultaneous events on one edge:
  - Write and alloc to the same register: data is written and busy ends at 1.
  - Two writes to the same register: the higher port's data is stored, and busy is cleared.
- The block has no handshake. The producer must not issue wr_en for registers it never allocated; the scoreboard does not check this.

## Test plan
- Reset: load x5=0xDEADBEEF, then assert rst asynchronously between edges -> x5 reads 0 before the next edge, and busy_vec=0.
- x0 protection: write 0x12345678 to address 0 with alloc_en on address 0 -> rs_data reads 0, rs_busy=0, and busy_vec[0]=0.
- Bypass: BYPASS=1, write x7=0xA5A5A5A5 while port 0 reads x7 in the same cycle -> rs_data port 0 = 0xA5A5A5A5 that cycle. With BYPASS=0 -> old value that cycle, new value the next cycle.
- Write priority: NWR=2, ports 0 and 1 write x3 with 0x1 and 0x2 in the same cycle -> x3=0x2 afterwards, and the bypass read returns 0x2.
- Scoreboard: alloc x9, then idle 2 cycles -> rs_busy set for reads of x9. Then write x9=0x55 -> in the write cycle rs_busy=0 (BYPASS=1) while busy_vec[9] is still 1; after the edge busy_vec[9]=0.
- Set/clear collision: write x4 and alloc x4 in the same cycle -> x4 holds the new data and busy_vec[4]=1 after the edge.
